// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle shift-add multiply / restoring divide with HI/LO registers
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             dz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;
    logic               rneg_q, rneg_d;
    logic               bz_q, bz_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;

    logic               accept, a_neg, b_neg, div_ge;
    logic [WIDTH-1:0]   a_mag, b_mag, quo, rem, fin_hi, fin_lo;
    logic [WIDTH:0]     mul_sum, div_t, div_diff;
    logic [2*WIDTH-1:0] iter, prod_fix;

    // Operand magnitudes, one iteration step of the engine, and the sign-corrected final result
    always_comb begin
        accept   = start && (state_q == S_IDLE);
        a_neg    = op[0] & a[WIDTH-1];
        b_neg    = op[0] & b[WIDTH-1];
        a_mag    = a_neg ? -a : a;
        b_mag    = b_neg ? -b : b;
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
        div_t    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff = div_t - {1'b0, b_q};
        div_ge   = !div_diff[WIDTH];
        iter     = is_div_q ? {div_ge ? div_diff[WIDTH-1:0] : div_t[WIDTH-1:0], acc_q[WIDTH-2:0], div_ge}
                            : {mul_sum, acc_q[WIDTH-1:1]};
        prod_fix = neg_q ? -iter : iter;
        quo      = neg_q ? -iter[WIDTH-1:0] : iter[WIDTH-1:0];
        rem      = rneg_q ? -iter[2*WIDTH-1:WIDTH] : iter[2*WIDTH-1:WIDTH];
        fin_hi   = is_div_q ? (bz_q ? a_q : rem) : prod_fix[2*WIDTH-1:WIDTH];
        fin_lo   = is_div_q ? (bz_q ? '1 : quo) : prod_fix[WIDTH-1:0];
    end

    // Control FSM: accept in IDLE, iterate WIDTH times in RUN, publish HI/LO on entry to FIX
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        bz_d     = bz_q;
        dz_d     = dz_q;
        a_d      = a_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        acc_d    = acc_q;
        if (accept && op[2:1] == 2'b10) begin
            hi_d = op[0] ? hi_q : a;
            lo_d = op[0] ? a : lo_q;
        end else if (accept && !op[2]) begin
            state_d  = S_RUN;
            cnt_d    = CW'(WIDTH - 1);
            is_div_d = op[1];
            neg_d    = a_neg ^ b_neg;
            rneg_d   = a_neg;
            bz_d     = (b == '0);
            dz_d     = 1'b0;
            a_d      = a;
            b_d      = b_mag;
            acc_d    = {{WIDTH{1'b0}}, a_mag};
        end else if (state_q == S_RUN) begin
            acc_d = iter;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) begin
                state_d = S_FIX;
                hi_d    = fin_hi;
                lo_d    = fin_lo;
                dz_d    = is_div_q & bz_q;
            end
        end else if (state_q == S_FIX) begin
            state_d = S_IDLE;
        end
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            bz_q     <= 1'b0;
            dz_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            acc_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            bz_q     <= bz_d;
            dz_q     <= dz_d;
            a_q      <= a_d;
            b_q      <= b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            acc_q    <= acc_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_FIX);
    assign dz   = dz_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule
